// File: rtl/video_pattern_gen.sv
// Parametrised video timing generator with runtime-selectable RGB test patterns.
// Produces registered de/hs/vs/rgb one cycle after the h/v counter state.
module video_pattern_gen #(
  parameter int          H_ACTIVE   = 64,
  parameter int          H_FP       = 4,
  parameter int          H_SYNC     = 8,
  parameter int          H_BP       = 4,
  parameter int          V_ACTIVE   = 64,
  parameter int          V_FP       = 2,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 2,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int          CHECK_LOG2 = 3,
  parameter logic [23:0] SOLID_RGB  = 24'h808080
) (
  input  logic       hdmi_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       hdmi_de,
  output logic       hdmi_hs,
  output logic       hdmi_vs,
  output logic [7:0] hdmi_r,
  output logic [7:0] hdmi_g,
  output logic [7:0] hdmi_b,
  output logic       frame_start,
  output logic [1:0] cur_mode
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_W    = HW'(H_ACTIVE / 8);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    cur_mode_q, cur_mode_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          at_origin, active, in_hs, in_vs, chk_odd;
  logic [1:0]    mode_eff;
  logic [2:0]    bar_idx;
  logic [7:0]    ramp;
  logic [23:0]   bar_rgb, pix_rgb;

  assign at_origin = (h_q == '0) && (v_q == '0);
  assign active    = (h_q < H_ACT) && (v_q < V_ACT);
  assign in_hs     = (h_q >= HS_START) && (h_q < HS_END);
  assign in_vs     = (v_q >= VS_START) && (v_q < VS_END);
  // The (0,0) pixel already uses the mode being latched on that same cycle.
  assign mode_eff  = at_origin ? mode : cur_mode_q;

  assign bar_idx = 3'(h_q / BAR_W);
  assign ramp    = 8'(h_q);
  assign chk_odd = (((32'(h_q) ^ 32'(v_q)) >> CHECK_LOG2) & 32'd1) != 32'd0;

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    case (mode_eff)
      2'd0:    pix_rgb = SOLID_RGB;
      2'd1:    pix_rgb = bar_rgb;
      2'd2:    pix_rgb = {ramp, ramp, ramp};
      default: pix_rgb = chk_odd ? 24'h000000 : 24'hFFFFFF;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    h_d        = '0;
    v_d        = '0;
    cur_mode_d = cur_mode_q;
    de_d       = 1'b0;
    hs_d       = !HS_POL;
    vs_d       = !VS_POL;
    rgb_d      = '0;
    fs_d       = 1'b0;
    if (enable) begin
      if (at_origin) cur_mode_d = mode;
      de_d  = active;
      hs_d  = in_hs ? HS_POL : !HS_POL;
      vs_d  = in_vs ? VS_POL : !VS_POL;
      rgb_d = active ? pix_rgb : '0;
      fs_d  = at_origin;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous and beats enable.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      cur_mode_q <= 2'd0;
      de_q       <= 1'b0;
      hs_q       <= !HS_POL;
      vs_q       <= !VS_POL;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      cur_mode_q <= cur_mode_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
    end
  end

  assign hdmi_de     = de_q;
  assign hdmi_hs     = hs_q;
  assign hdmi_vs     = vs_q;
  assign hdmi_r      = rgb_q[23:16];
  assign hdmi_g      = rgb_q[15:8];
  assign hdmi_b      = rgb_q[7:0];
  assign frame_start = fs_q;
  assign cur_mode    = cur_mode_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a frame-position model derived from the count of
// enabled cycles predicts every output of two differently-parametrised instances.
module tb_video_pattern_gen;

  typedef struct packed {
    int          ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit          hpol, vpol;
    int          chk;
    logic [23:0] solid;
  } geom_t;

  typedef struct {
    logic        de, hs, vs, fs;
    logic [23:0] rgb;
    logic [1:0]  cm;
    int          h, v;
  } exp_t;

  localparam geom_t GA = '{ha:64, hfp:4, hsw:8, hbp:4, va:64, vfp:2, vsw:2, vbp:2,
                           hpol:1'b1, vpol:1'b1, chk:3, solid:24'h808080};
  localparam geom_t GB = '{ha:640, hfp:4, hsw:8, hbp:4, va:2, vfp:2, vsw:2, vbp:2,
                           hpol:1'b0, vpol:1'b0, chk:3, solid:24'h808080};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;

  logic       de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [1:0] cm_a, cm_b;

  int   n_checks = 0;
  int   n_err    = 0;
  int   run_a = 0, run_b = 0;
  logic [1:0] fm_a = 2'd0, fm_b = 2'd0;
  exp_t ea, eb;
  bit   model_valid = 1'b0;

  always #5 clk = ~clk;

  video_pattern_gen dut_a (
    .hdmi_clk(clk), .rst(rst), .enable(en_a), .mode(mode_a),
    .hdmi_de(de_a), .hdmi_hs(hs_a), .hdmi_vs(vs_a),
    .hdmi_r(r_a), .hdmi_g(g_a), .hdmi_b(b_a),
    .frame_start(fs_a), .cur_mode(cm_a)
  );

  video_pattern_gen #(
    .H_ACTIVE(640), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(2), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(3), .SOLID_RGB(24'h808080)
  ) dut_b (
    .hdmi_clk(clk), .rst(rst), .enable(en_b), .mode(mode_b),
    .hdmi_de(de_b), .hdmi_hs(hs_b), .hdmi_vs(vs_b),
    .hdmi_r(r_b), .hdmi_g(g_b), .hdmi_b(b_b),
    .frame_start(fs_b), .cur_mode(cm_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [23:0] pattern(input geom_t g, input int h, input int v,
                                          input logic [1:0] m);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m)
      2'd0:    return g.solid;
      2'd1:    return bars[h / (g.ha / 8)];
      2'd2:    return {3{8'(h % 256)}};
      default: return ((((h >> g.chk) ^ (v >> g.chk)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Position within the frame is simply the number of enabled cycles since the
  // last restart, modulo the frame size.
  task automatic model_step(input geom_t g, input logic rs, input logic en,
                            input logic [1:0] m, inout int run, inout logic [1:0] fm,
                            output exp_t e);
    int ht, vt, pos, h, v;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    e.de = 1'b0; e.hs = !g.hpol; e.vs = !g.vpol; e.fs = 1'b0; e.rgb = '0;
    e.h = -1; e.v = -1;
    if (rs) begin
      run = 0;
      fm  = 2'd0;
    end else if (!en) begin
      run = 0;
    end else begin
      pos = run % (ht * vt);
      h   = pos % ht;
      v   = pos / ht;
      if (pos == 0) fm = m;
      e.h   = h;
      e.v   = v;
      e.de  = (h < g.ha) && (v < g.va);
      e.hs  = (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw) ? g.hpol : !g.hpol;
      e.vs  = (v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw) ? g.vpol : !g.vpol;
      e.rgb = e.de ? pattern(g, h, v, fm) : 24'h0;
      e.fs  = (pos == 0);
      run++;
    end
    e.cm = fm;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(GA, rst, en_a, mode_a, run_a, fm_a, ea);
      model_step(GB, rst, en_b, mode_b, run_b, fm_b, eb);
      model_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("a.de",  32'(de_a), 32'(ea.de));
        check("a.hs",  32'(hs_a), 32'(ea.hs));
        check("a.vs",  32'(vs_a), 32'(ea.vs));
        check("a.fs",  32'(fs_a), 32'(ea.fs));
        check("a.rgb", 32'({r_a, g_a, b_a}), 32'(ea.rgb));
        check("a.cur_mode", 32'(cm_a), 32'(ea.cm));
        check("b.de",  32'(de_b), 32'(eb.de));
        check("b.hs",  32'(hs_b), 32'(eb.hs));
        check("b.vs",  32'(vs_b), 32'(eb.vs));
        check("b.fs",  32'(fs_b), 32'(eb.fs));
        check("b.rgb", 32'({r_b, g_b, b_b}), 32'(eb.rgb));
        check("b.cur_mode", 32'(cm_b), 32'(eb.cm));
        // Hand-computed values pinning the model itself.
        if (ea.cm == 2'd1 && ea.v == 0 && ea.h == 8)  check("pin bar1",  32'({r_a, g_a, b_a}), 32'h00FFFF00);
        if (ea.cm == 2'd1 && ea.v == 3 && ea.h == 56) check("pin bar7",  32'({r_a, g_a, b_a}), 32'h00000000);
        if (ea.cm == 2'd1 && ea.v == 3 && ea.h == 20) check("pin bar2",  32'({r_a, g_a, b_a}), 32'h0000FFFF);
        if (ea.cm == 2'd3 && ea.v == 0 && ea.h == 0)  check("pin chk00", 32'({r_a, g_a, b_a}), 32'h00FFFFFF);
        if (ea.cm == 2'd3 && ea.v == 0 && ea.h == 8)  check("pin chk80", 32'({r_a, g_a, b_a}), 32'h00000000);
        if (ea.cm == 2'd3 && ea.v == 8 && ea.h == 8)  check("pin chk88", 32'({r_a, g_a, b_a}), 32'h00FFFFFF);
        if (ea.cm == 2'd2 && ea.v == 20 && ea.h == 5) check("pin ramp5", 32'({r_a, g_a, b_a}), 32'h00050505);
        if (ea.v == 5 && ea.h == 67)  check("pin hs67", 32'(hs_a), 32'd0);
        if (ea.v == 5 && ea.h == 68)  check("pin hs68", 32'(hs_a), 32'd1);
        if (ea.v == 5 && ea.h == 75)  check("pin hs75", 32'(hs_a), 32'd1);
        if (ea.v == 5 && ea.h == 76)  check("pin hs76", 32'(hs_a), 32'd0);
        if (ea.v == 65 && ea.h == 10) check("pin vs65", 32'(vs_a), 32'd0);
        if (ea.v == 66 && ea.h == 10) check("pin vs66", 32'(vs_a), 32'd1);
        if (ea.v == 67 && ea.h == 79) check("pin vs67", 32'(vs_a), 32'd1);
        if (ea.v == 63 && ea.h == 63) check("pin de_last", 32'(de_a), 32'd1);
        if (ea.v == 0 && ea.h == 64)  check("pin de_blank", 32'(de_a), 32'd0);
        if (eb.cm == 2'd2 && eb.v == 1 && eb.h == 300) check("pin b.ramp300", 32'({r_b, g_b, b_b}), 32'h002C2C2C);
        if (eb.v == 0 && eb.h == 646) check("pin b.hs_sync", 32'(hs_b), 32'd0);
        if (eb.v == 0 && eb.h == 10)  check("pin b.hs_idle", 32'(hs_b), 32'd1);
        if (eb.v == 4 && eb.h == 10)  check("pin b.vs_sync", 32'(vs_b), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int off;
    @(negedge clk);
    check("rst de",       32'(de_a), 32'd0);
    check("rst hs_a",     32'(hs_a), 32'd0);
    check("rst hs_b",     32'(hs_b), 32'd1);
    check("rst vs_b",     32'(vs_b), 32'd1);
    check("rst cur_mode", 32'(cm_a), 32'd0);
    tick(2);
    rst = 1'b0; en_a = 1'b1; en_b = 1'b1; mode_b = 2'd2;
    tick(1);
    check("first de",  32'(de_a), 32'd1);
    check("first fs",  32'(fs_a), 32'd1);
    check("first rgb", 32'({r_a, g_a, b_a}), 32'h00808080);

    // Frame 0 solid, 1 bars, 2 checker, 3 ramp.
    tick(2799);  mode_a = 2'd1;
    tick(5600);  mode_a = 2'd3;
    tick(5600);  mode_a = 2'd2;
    tick(2800);
    // Frame 3 is now at (0,0); switch to solid at line 10, seen only in frame 4.
    tick(10 * 80 + 5); mode_a = 2'd0;
    tick(2 * 5600 - (10 * 80 + 5));
    // Change on the very (0,0) cycle of frame 5 is captured.
    mode_a = 2'd3;
    tick(30 * 80 + 20);
    en_a = 1'b0;
    tick(5);
    en_a = 1'b1;
    tick(6000);

    off = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) mode_a = 2'($urandom);
      if ($urandom_range(0, 299) == 0) mode_b = 2'($urandom);
      if (off > 0) begin
        off--;
        if (off == 0) en_a = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        en_a = 1'b0;
        off  = int'($urandom_range(1, 8));
      end
      if ($urandom_range(0, 3999) == 0) en_b = 1'b0;
      else if (!en_b && $urandom_range(0, 3) == 0) en_b = 1'b1;
      rst = (i >= 7000 && i < 7002);
      tick(1);
    end
    rst = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Synthesisable, parametrised video source: generates full HDMI-style timing (de/hs/vs) with configurable porches, sync widths and polarities, plus RGB test-pattern pixels.
- Replaces file-driven stimulus in both hardware and simulation.
- Feeds vp processing stages or drives the HDMI output directly.
- Pattern mode is runtime-selectable and changes only on frame boundaries.

Parameters:
H_ACTIVE, 64, active pixels per line; multiple of 8, ≥8
H_FP, 4, horizontal front porch (pixels), ≥1
H_SYNC, 8, horizontal sync width (pixels), ≥1
H_BP, 4, horizontal back porch (pixels), ≥1
V_ACTIVE, 64, active lines per frame, ≥2
V_FP, 2, vertical front porch (lines), ≥1
V_SYNC, 2, vertical sync width (lines), ≥1
V_BP, 2, vertical back porch (lines), ≥1
HS_POL, 1, hs level during sync (1 = active-high)
VS_POL, 1, vs level during sync
CHECK_LOG2, 3, checker square size = 2^CHECK_LOG2 pixels
SOLID_RGB, 24'h808080, colour for solid mode, ordered {R,G,B}

Ports:
hdmi_clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = run timing; 0 = hold counters at origin
mode  in  2  0 solid, 1 colour bars, 2 horizontal ramp, 3 checkerboard
hdmi_de  out  1  data enable (active video)
hdmi_hs  out  1  horizontal sync, polarity HS_POL
hdmi_vs  out  1  vertical sync, polarity VS_POL
hdmi_r  out  8  red
hdmi_g  out  8  green
hdmi_b  out  8  blue
frame_start  out  1  one-cycle pulse on the first active pixel of each frame
cur_mode  out  2  mode in effect for the current frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Default: 80 × 70.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Counters advance only when enable=1.
- Counter regions:
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs asserted: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted: V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- All outputs are registered with 1-cycle latency from the counter state. de, hs, vs and rgb are mutually aligned.
- Outside the active region, rgb=0.
- Mode latch:
  - cur_mode loads mode on the cycle the counters sit at (0,0) with enable=1.
  - mode changes at any other time are ignored until the next frame.
- frame_start = 1 on the same output cycle as the pixel from (0,0).
- Patterns, evaluated per active pixel at (h,v):
  - Mode 0: {r,g,b}=SOLID_RGB.
  - Mode 1: bar = h/(H_ACTIVE/8). Bars 0..7 are white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Mode 2: r=g=b=h[7:0]; wraps modulo 256 for H_ACTIVE>256.
  - Mode 3: h[CHECK_LOG2]^v[CHECK_LOG2] = 0 → FFFFFF, else 000000.
- enable=0:
  - Next cycle: counters=0, de=0, hs=!HS_POL, vs=!VS_POL, rgb=0, frame_start=0.
  - Re-enabling starts a fresh frame at (0,0), which latches mode.
- rst=1:
  - Same output values as enable=0.
  - cur_mode=0.
  - rst overrides enable.
  - Reset mid-frame aborts the frame; no partial-frame state persists.
- Simultaneous mode change and frame start: the value present on the (0,0) cycle is captured.
- Counter widths are clog2(H_TOTAL) and clog2(V_TOTAL); no overflow beyond the wrap point.

Test Plan:
- Defaults, rst 3 cycles then enable=1 → first de high 1 cycle after enable; 64 de cycles per line; de low 16 cycles; hs low→high for cycles 68..75 of each line; 64 active lines of 70; vs high on lines 66–67.
- mode=1 → line pixels 0–7 FFFFFF, 8–15 FFFF00, …, 56–63 000000; rgb=0 during blanking.
- mode=3, CHECK_LOG2=3 → (0,0)=FFFFFF, (8,0)=000000, (8,8)=FFFFFF.
- Switch mode 2→0 mid-frame at line 10 → ramp (pixel 5 = 050505) continues to frame end; next frame is 808080; cur_mode changes at the (0,0) cycle.
- enable dropped at line 30, pixel 20, held 5 cycles, then reasserted → de=0 and syncs inactive while low; frame_start pulses once when restarting at (0,0).
- HS_POL=0, VS_POL=0, H_ACTIVE=640 → hs idles high and pulses low; mode 2 pixel 300 = 2C2C2C (wrap).
